exp_handler_pipe: RTL and testbench

Pipelined, multi-lane successor of the FMA exponent handler for the vector FPU. Per lane, it computes three values: exp_a+exp_b, the alignment reference exp_tmp = max(exp_a+exp_b+OFF, exp_c), and the clamped addend right-shift amount. It also flags shift saturation. It sits between operand unpack and the addend aligner, carries a valid/ready handshake, and supports an FMUL mode that ignores the addend.

---
 rtl/exp_handler_pipe.sv | 189 ++++++++++++++++++
 tb/tb_exp_handler_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_handler_pipe.sv
// Two-stage, multi-lane FMA exponent handler: exp_a+exp_b, alignment reference and addend shift.
// Optional zero-operand overrides are built when EXP_HANDLER_PIPE_ZERO_EN is defined.
module exp_handler_pipe #(
  parameter int LANES = 4,
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  localparam int OFF     = MAN_W + 3,
  localparam int SHF_MAX = 3 * MAN_W + 2,
  localparam int SHF_W   = $clog2(SHF_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         fma_mode,
  input  logic [LANES*EXP_W-1:0]       exp_a,
  input  logic [LANES*EXP_W-1:0]       exp_b,
  input  logic [LANES*EXP_W-1:0]       exp_c,
`ifdef EXP_HANDLER_PIPE_ZERO_EN
  input  logic [LANES-1:0]             zero_a,
  input  logic [LANES-1:0]             zero_b,
  input  logic [LANES-1:0]             zero_c,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*(EXP_W+1)-1:0]   exp_ab,
  output logic [LANES*(EXP_W+2)-1:0]   exp_tmp,
  output logic [LANES*SHF_W-1:0]       shf_num,
  output logic [LANES-1:0]             sat_lo,
  output logic [LANES-1:0]             sat_hi
);

  localparam int AB_W = EXP_W + 1;
  localparam int DW   = EXP_W + 2;

  localparam logic signed [DW-1:0]  OFF_D     = DW'(OFF);
  localparam logic signed [DW-1:0]  LO_LIM    = DW'(OFF - SHF_MAX);
  localparam logic [SHF_W-1:0]      SHF_MAX_V = SHF_W'(SHF_MAX);

  logic en;

  // Stage 1 combinational results
  logic signed [AB_W-1:0] ab_d  [LANES];
  logic signed [DW-1:0]   abo_d [LANES];
  logic signed [DW-1:0]   d_d   [LANES];

  // Stage 1 registers
  logic                   s1_valid_q;
  logic                   s1_fma_q;
  logic [LANES*AB_W-1:0]  s1_ab_q;
  logic [LANES*EXP_W-1:0] s1_c_q;
  logic signed [DW-1:0]   s1_abo_q [LANES];
  logic signed [DW-1:0]   s1_d_q   [LANES];
  logic [LANES-1:0]       zab_s1;
  logic [LANES-1:0]       zc_s1;

  // Stage 2 combinational results
  logic signed [DW-1:0]   c_ext [LANES];
  logic [LANES*DW-1:0]    exp_tmp_d;
  logic [LANES*SHF_W-1:0] shf_d;
  logic [LANES-1:0]       lo_d;
  logic [LANES-1:0]       hi_d;

  // Output registers
  logic                   out_valid_q;
  logic [LANES*AB_W-1:0]  exp_ab_q;
  logic [LANES*DW-1:0]    exp_tmp_q;
  logic [LANES*SHF_W-1:0] shf_q;
  logic [LANES-1:0]       sat_lo_q;
  logic [LANES-1:0]       sat_hi_q;

  // A single enable moves the whole pipe; a stalled output freezes everything behind it.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ab_d[i]  = {exp_a[i*EXP_W+EXP_W-1], exp_a[i*EXP_W +: EXP_W]}
               + {exp_b[i*EXP_W+EXP_W-1], exp_b[i*EXP_W +: EXP_W]};
      abo_d[i] = {ab_d[i][AB_W-1], ab_d[i]} + OFF_D;
      d_d[i]   = {{2{exp_c[i*EXP_W+EXP_W-1]}}, exp_c[i*EXP_W +: EXP_W]}
               - {ab_d[i][AB_W-1], ab_d[i]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process evaluation order.
  // NOTE: data registers are reset too (not only the valids) because the outputs
  // must read as zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fma_q   <= 1'b0;
      s1_ab_q    <= '0;
      s1_c_q     <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_abo_q[i] <= '0;
        s1_d_q[i]   <= '0;
      end
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_fma_q   <= fma_mode;
      s1_c_q     <= exp_c;
      for (int i = 0; i < LANES; i++) begin
        s1_ab_q[i*AB_W +: AB_W] <= ab_d[i];
        s1_abo_q[i]             <= abo_d[i];
        s1_d_q[i]               <= d_d[i];
      end
    end
  end

`ifdef EXP_HANDLER_PIPE_ZERO_EN
  logic [LANES-1:0] zab_q;
  logic [LANES-1:0] zc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zab_q <= '0;
      zc_q  <= '0;
    end else if (en) begin
      zab_q <= zero_a | zero_b;
      zc_q  <= zero_c;
    end
  end

  assign zab_s1 = zab_q;
  assign zc_s1  = zc_q;
`else
  assign zab_s1 = '0;
  assign zc_s1  = '0;
`endif

  // NOTE: every always_comb output gets a default before any branch, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    exp_tmp_d = '0;
    shf_d     = '0;
    lo_d      = '0;
    hi_d      = '0;
    for (int i = 0; i < LANES; i++) begin
      c_ext[i] = {{2{s1_c_q[i*EXP_W+EXP_W-1]}}, s1_c_q[i*EXP_W +: EXP_W]};
      if (zab_s1[i] && s1_fma_q) begin
        exp_tmp_d[i*DW +: DW] = c_ext[i];
        lo_d[i]               = 1'b1;
      end else if (zc_s1[i] || !s1_fma_q) begin
        exp_tmp_d[i*DW +: DW]   = s1_abo_q[i];
        shf_d[i*SHF_W +: SHF_W] = SHF_MAX_V;
        hi_d[i]                 = zc_s1[i];
      end else begin
        exp_tmp_d[i*DW +: DW] = (c_ext[i] >= s1_abo_q[i]) ? c_ext[i] : s1_abo_q[i];
        if (s1_d_q[i] > OFF_D) begin
          lo_d[i] = 1'b1;
        end else if (s1_d_q[i] < LO_LIM) begin
          shf_d[i*SHF_W +: SHF_W] = SHF_MAX_V;
          hi_d[i]                 = 1'b1;
        end else begin
          // In this window OFF-d lies in [0, SHF_MAX], so truncation is exact.
          shf_d[i*SHF_W +: SHF_W] = SHF_W'(OFF_D - s1_d_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      exp_ab_q    <= '0;
      exp_tmp_q   <= '0;
      shf_q       <= '0;
      sat_lo_q    <= '0;
      sat_hi_q    <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      exp_ab_q    <= s1_ab_q;
      exp_tmp_q   <= exp_tmp_d;
      shf_q       <= shf_d;
      sat_lo_q    <= lo_d;
      sat_hi_q    <= hi_d;
    end
  end

  assign out_valid = out_valid_q;
  assign exp_ab    = exp_ab_q;
  assign exp_tmp   = exp_tmp_q;
  assign shf_num   = shf_q;
  assign sat_lo    = sat_lo_q;
  assign sat_hi    = sat_hi_q;

endmodule

// File: tb/tb_exp_handler_pipe.sv
// Bench for exp_handler_pipe: directed vectors, handshake/reset sequences and random
// traffic scored against an integer reference model.
module tb_exp_handler_pipe;

  localparam int LANES   = 4;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 24;
  localparam int OFF     = MAN_W + 3;
  localparam int SHF_MAX = 3 * MAN_W + 2;
  localparam int SHF_W   = 7;
  localparam int AB_W    = EXP_W + 1;
  localparam int DW      = EXP_W + 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_valid;
  logic                       in_ready;
  logic                       fma_mode;
  logic [LANES*EXP_W-1:0]     exp_a, exp_b, exp_c;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*AB_W-1:0]      exp_ab;
  logic [LANES*DW-1:0]        exp_tmp;
  logic [LANES*SHF_W-1:0]     shf_num;
  logic [LANES-1:0]           sat_lo, sat_hi;

  always #5 clk = ~clk;

  exp_handler_pipe #(.LANES(LANES), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fma_mode(fma_mode), .exp_a(exp_a), .exp_b(exp_b), .exp_c(exp_c),
    .out_valid(out_valid), .out_ready(out_ready), .exp_ab(exp_ab),
    .exp_tmp(exp_tmp), .shf_num(shf_num), .sat_lo(sat_lo), .sat_hi(sat_hi)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  typedef struct packed { int ab; int tmp; int shf; bit lo; bit hi; } lane_t;
  typedef lane_t [LANES-1:0] txn_t;

  typedef struct {
    bit fma; int a; int b; int c;
    int ab; int tmp; int shf; bit lo; bit hi;
  } vec_t;

  // Reference: plain integer arithmetic straight from the exponent rules.
  function automatic lane_t model(bit fma, int a, int b, int c);
    lane_t r;
    int d;
    r.ab = a + b;
    d    = c - r.ab;
    if (!fma) begin
      r.tmp = r.ab + OFF; r.shf = SHF_MAX; r.lo = 1'b0; r.hi = 1'b0;
    end else begin
      r.tmp = (c > r.ab + OFF) ? c : r.ab + OFF;
      r.shf = OFF - d;
      if (r.shf < 0) r.shf = 0;
      if (r.shf > SHF_MAX) r.shf = SHF_MAX;
      r.lo = (d > OFF);
      r.hi = (d < OFF - SHF_MAX);
    end
    return r;
  endfunction

  function automatic int lane_in(logic [LANES*EXP_W-1:0] v, int i);
    logic signed [EXP_W-1:0] s;
    s = v[i*EXP_W +: EXP_W];
    return int'(s);
  endfunction

  function automatic int f_ab(int i);
    logic signed [AB_W-1:0] s;
    s = exp_ab[i*AB_W +: AB_W];
    return int'(s);
  endfunction

  function automatic int f_tmp(int i);
    logic signed [DW-1:0] s;
    s = exp_tmp[i*DW +: DW];
    return int'(s);
  endfunction

  function automatic int f_shf(int i);
    return int'(shf_num[i*SHF_W +: SHF_W]);
  endfunction

  task automatic set_lane(input int i, input int a, input int b, input int c);
    exp_a[i*EXP_W +: EXP_W] = a[EXP_W-1:0];
    exp_b[i*EXP_W +: EXP_W] = b[EXP_W-1:0];
    exp_c[i*EXP_W +: EXP_W] = c[EXP_W-1:0];
  endtask

  task automatic rand_inputs();
    int a, b, c;
    fma_mode = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < LANES; i++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      case ($urandom_range(0, 3))
        0:       c = a + b + OFF + int'($urandom_range(0, 2)) - 1;
        1:       c = a + b + OFF - SHF_MAX + int'($urandom_range(0, 2)) - 1;
        default: c = int'($urandom_range(0, 255)) - 128;
      endcase
      if (c > 127)  c = 127;
      if (c < -128) c = -128;
      set_lane(i, a, b, c);
    end
  endtask

  // Scoreboard monitor: pushes accepted inputs, pops on output handshakes,
  // and checks that a stalled output holds.
  txn_t sb[$];
  bit   stall_pending = 1'b0;
  logic [LANES*AB_W-1:0]  sv_ab;
  logic [LANES*DW-1:0]    sv_tmp;
  logic [LANES*SHF_W-1:0] sv_shf;
  logic [2*LANES-1:0]     sv_sat;

  always @(negedge clk) begin
    txn_t e;
    if (rst) begin
      sb.delete();
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("stall_valid", out_valid, 1);
        check("stall_ab", exp_ab, sv_ab);
        check("stall_tmp", exp_tmp, sv_tmp);
        check("stall_shf", shf_num, sv_shf);
        check("stall_sat", {sat_lo, sat_hi}, sv_sat);
      end
      check("in_ready_en", in_ready, (!out_valid) || out_ready);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < LANES; i++) begin
            check($sformatf("sb_L%0d_ab", i),  f_ab(i),  e[i].ab);
            check($sformatf("sb_L%0d_tmp", i), f_tmp(i), e[i].tmp);
            check($sformatf("sb_L%0d_shf", i), f_shf(i), e[i].shf);
            check($sformatf("sb_L%0d_lo", i),  sat_lo[i], e[i].lo);
            check($sformatf("sb_L%0d_hi", i),  sat_hi[i], e[i].hi);
          end
        end
      end
      stall_pending = out_valid && !out_ready;
      sv_ab = exp_ab; sv_tmp = exp_tmp; sv_shf = shf_num; sv_sat = {sat_lo, sat_hi};
      if (in_valid && in_ready) begin
        for (int i = 0; i < LANES; i++)
          e[i] = model(fma_mode, lane_in(exp_a, i), lane_in(exp_b, i), lane_in(exp_c, i));
        sb.push_back(e);
      end
    end
  end

  // One transaction on an idle pipe, compared against hand-derived constants.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit found;
    @(posedge clk); #1;
    fma_mode  = v.fma;
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) set_lane(i, v.a, v.b, v.c);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    found = 1'b0;
    while (!found && lat <= 6) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, 2);
    if (found) begin
      for (int i = 0; i < LANES; i++) begin
        check($sformatf("v%0d_L%0d_ab", idx, i),  f_ab(i),  v.ab);
        check($sformatf("v%0d_L%0d_tmp", idx, i), f_tmp(i), v.tmp);
        check($sformatf("v%0d_L%0d_shf", idx, i), f_shf(i), v.shf);
        check($sformatf("v%0d_L%0d_lo", idx, i),  sat_lo[i], v.lo);
        check($sformatf("v%0d_L%0d_hi", idx, i),  sat_hi[i], v.hi);
      end
    end
  endtask

  // mode 0: out_ready pattern 1,0,0,1; mode 1: random traffic; mode 2: always ready.
  task automatic stream(input int n, input int mode, input string name);
    int sent = 0;
    int cyc = 0;
    bit acc = 1'b0;
    in_valid = 1'b0;
    while (sent < n && cyc < 4000) begin
      @(posedge clk); #1;
      if (acc) sent++;
      if (acc || !in_valid) begin
        if (sent < n && (mode != 1 || $urandom_range(0, 9) < 8)) begin
          rand_inputs();
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      case (mode)
        0:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        1:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = 1'b1;
      endcase
      cyc++;
      #1 acc = in_valid && in_ready;
    end
    check({name, "_sent"}, sent, n);
    if (mode == 2) check({name, "_full_rate"}, cyc, n + 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({name, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{1, 3,    4,    10,   7,    34,   24, 0, 0};
    vecs[1] = '{1, 3,    4,    100,  7,    100,  0,  1, 0};
    vecs[2] = '{1, 127,  127,  -128, 254,  281,  74, 0, 1};
    vecs[3] = '{1, 0,    0,    27,   0,    27,   0,  0, 0};
    vecs[4] = '{1, 0,    0,    28,   0,    28,   0,  1, 0};
    vecs[5] = '{1, 0,    0,    -47,  0,    27,   74, 0, 0};
    vecs[6] = '{1, 0,    0,    -48,  0,    27,   74, 0, 1};
    vecs[7] = '{0, -10,  5,    120,  -5,   22,   74, 0, 0};
    vecs[8] = '{1, -128, -128, 127,  -256, 127,  0,  1, 0};
    vecs[9] = '{1, -128, -128, -128, -256, -128, 0,  1, 0};

    rst = 1'b1; in_valid = 1'b0; fma_mode = 1'b0; out_ready = 1'b0;
    exp_a = '0; exp_b = '0; exp_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_exp_ab", exp_ab, 0);
    check("rst_exp_tmp", exp_tmp, 0);
    check("rst_shf", shf_num, 0);
    check("rst_sat", {sat_lo, sat_hi}, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

    stream(6, 0, "pattern");
    stream(8, 2, "fullrate");
    stream(300, 1, "random");

    // Reset with two transactions in flight.
    @(posedge clk); #1;
    out_ready = 1'b1;
    rand_inputs(); in_valid = 1'b1;
    @(posedge clk); #1;
    rand_inputs(); in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_exp_ab", exp_ab, 0);
    check("midrst_exp_tmp", exp_tmp, 0);
    check("midrst_shf", shf_num, 0);
    check("midrst_sat", {sat_lo, sat_hi}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    check("postrst_out_valid", out_valid, 0);
    run_vec(vecs[0], 10);
    @(posedge clk);
    @(negedge clk);
    check("postrst_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
